// File: rtl/truth_table_sequencer.sv
// Sweeps {a,b,c} through 000..111, holding each vector for DWELL clocks, and captures y_in into an 8-bit truth table.
// Optional golden-table compare is enabled by defining TT_CHECK_EN.
module truth_table_sequencer #(
  parameter int         DWELL    = 100,
  parameter int         CNT_W    = 16,
  parameter logic [7:0] EXPECTED = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       tt_q, tt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
    end
  end

  // y_in is sampled on the last clock of each hold, giving the unit DWELL clocks to settle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tt_d    = tt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 3'd0;
          cnt_d   = '0;
          tt_d    = 8'h00;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == CntLast) begin
          tt_d[idx_q] = y_in;
          cnt_d       = '0;
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

`ifdef TT_CHECK_EN
  logic mismatch_q, mismatch_d;

  // Compare the table as it will be after the final capture, so the flag is valid with done.
  always_comb begin
    mismatch_d = mismatch_q;
    if (state_q != RUN && start) begin
      mismatch_d = 1'b0;
    end else if (state_q == RUN && state_d == DONE) begin
      mismatch_d = (tt_d != EXPECTED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  // EXPECTED stays referenced but the expression folds to a constant 0.
  assign mismatch = 1'b0 & (^EXPECTED);
`endif

  assign a           = idx_q[2];
  assign b           = idx_q[1];
  assign c           = idx_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with DWELL=4 driving a model unit Y = (A&B)|C (golden table 8'hEA).
module tb_truth_table_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       yIn;
  logic       a, b, c;
  logic       busy, done;
  logic [7:0] truthTable;
  logic       mismatch;

  int errorCount;
  int checkCount;

  truth_table_sequencer #(
    .DWELL   (4),
    .CNT_W   (3),
    .EXPECTED(8'hEA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y_in       (yIn),
    .a          (a),
    .b          (b),
    .c          (c),
    .busy       (busy),
    .done       (done),
    .truth_table(truthTable),
    .mismatch   (mismatch)
  );

  assign yIn = (a & b) | c;

`ifdef TT_CHECK_EN
  logic       a2, b2, c2, busy2, done2, mismatch2;
  logic [7:0] truthTable2;
  logic       yIn2;

  truth_table_sequencer #(
    .DWELL   (4),
    .CNT_W   (3),
    .EXPECTED(8'hEB)
  ) dutBad (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .y_in       (yIn2),
    .a          (a2),
    .b          (b2),
    .c          (c2),
    .busy       (busy2),
    .done       (done2),
    .truth_table(truthTable2),
    .mismatch   (mismatch2)
  );

  assign yIn2 = (a2 & b2) | c2;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_abc"}, {29'd0, a, b, c}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_table"}, {24'd0, truthTable}, 32'd0);
    checkOutput({tag, "_mismatch"}, {31'd0, mismatch}, 32'd0);
  endtask

  // Called at a negedge; start is raised here and sampled on the next posedge (E0).
  // Checks every clock of the sweep and the completion state after E32.
  task automatic applyStimulus(input string tag, input int pulseAt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_first_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_first_table"}, {24'd0, truthTable}, 32'd0);
    for (int n = 0; n < 32; n++) begin
      checkOutput({tag, "_abc"}, {29'd0, a, b, c}, n / 4);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, "_done_low"}, {31'd0, done}, 32'd0);
      start = (n == pulseAt);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_end_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_end_table"}, {24'd0, truthTable}, 32'hEA);
    checkOutput({tag, "_end_abc"}, {29'd0, a, b, c}, 32'd7);
    checkOutput({tag, "_end_mismatch"}, {31'd0, mismatch}, 32'd0);
`ifdef TT_CHECK_EN
    checkOutput({tag, "_bad_mismatch"}, {31'd0, mismatch2}, 32'd1);
`endif
    @(negedge clk);
    checkOutput({tag, "_hold_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_hold_table"}, {24'd0, truthTable}, 32'hEA);
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkResetValues("por");
    repeat (3) @(negedge clk);

    // Asynchronous reset pulse while idle.
    #2 rst = 1'b1;
    #1 checkResetValues("idle_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("sweep", -1);
    applyStimulus("ignore_start", 12);

    // Reset in the middle of vector 5.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midop_abc_before", {29'd0, a, b, c}, 32'd5);
    #2 rst = 1'b1;
    #1 checkResetValues("midop_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midop_after");

    applyStimulus("clean", -1);
    applyStimulus("restart", -1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
